// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed hex display path (scanner and decoder).
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 2;
  localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'b1111;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [DIGIT_W-1:0] nibble_t;
  typedef logic [IDX_W-1:0]   digit_idx_t;
  typedef logic [NUM_DIGITS-1:0] digit_en_t;

  // Active-low one-hot select for a single digit.
  function automatic digit_en_t digit_select(input digit_idx_t idx);
    digit_en_t sel;
    sel      = DIGIT_OFF;
    sel[idx] = 1'b0;
    return sel;
  endfunction

  // Index of the most significant nonzero nibble; 0 when the whole frame is zero.
  function automatic digit_idx_t top_nonzero(input frame_t v);
    digit_idx_t top;
    top = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] != '0) top = digit_idx_t'(i);
    end
    return top;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: one-cycle tick on the terminal count of 0..SCAN_DIV-1.
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  // A one-bit counter is kept for SCAN_DIV=1; it simply stays at zero.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == TERMINAL);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed hex display scanner with a one-deep load slot and frame-aligned updates.
// Optional leading-zero suppression is enabled by defining DISPLAY_ZERO_BLANK_EN.
module display_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dataIn,
  input  logic        loadValue,
  input  logic        blank,
  output logic        ready,
  output logic [3:0]  hexValue,
  output logic [3:0]  digitEnable,
  output logic [1:0]  digitIndex
);

  logic       tick;
  logic       frame_end;
  logic       accept;

  digit_idx_t idx_q, idx_d;
  frame_t     pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  frame_t     disp_q, disp_d;
  digit_en_t  den_q, den_d;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign frame_end = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
  assign accept    = loadValue && !pend_vld_q;

  always_comb begin
    idx_d = tick ? idx_q + digit_idx_t'(1) : idx_q;
  end

  // A load on the boundary edge lands in the slot after the copy looked at it,
  // so it waits for the next boundary and never tears the current frame.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    if (accept) begin
      pend_d     = dataIn;
      pend_vld_d = 1'b1;
    end else if (frame_end && pend_vld_q) begin
      pend_vld_d = 1'b0;
    end
    if (frame_end && pend_vld_q) begin
      disp_d = pend_q;
    end
  end

  // Enables are computed from next-state index/data so they line up with hexValue.
  always_comb begin
    if (blank) begin
      den_d = DIGIT_OFF;
    end else begin
      den_d = digit_select(idx_d);
`ifdef DISPLAY_ZERO_BLANK_EN
      if (idx_d > top_nonzero(disp_d)) begin
        den_d = DIGIT_OFF;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      den_q      <= DIGIT_OFF;
    end else begin
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      den_q      <= den_d;
    end
  end

  assign ready       = !pend_vld_q;
  assign hexValue    = disp_q[idx_q*DIGIT_W +: DIGIT_W];
  assign digitEnable = den_q;
  assign digitIndex  = idx_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: three instances (SCAN_DIV 4, 2, 1) share one stimulus stream.
module tb_display_scanner;

  logic        clock;
  logic        reset;
  logic        loadValue;
  logic        blank;
  logic [15:0] dataIn;

  logic       rdy4, rdy2, rdy1;
  logic [3:0] hex4, hex2, hex1;
  logic [3:0] den4, den2, den1;
  logic [1:0] idx4, idx2, idx1;

  int checks = 0;
  int errors = 0;
  int edge_n;

`ifdef DISPLAY_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  display_scanner #(.SCAN_DIV(4)) dut4 (
    .clock(clock), .reset(reset), .dataIn(dataIn), .loadValue(loadValue), .blank(blank),
    .ready(rdy4), .hexValue(hex4), .digitEnable(den4), .digitIndex(idx4));

  display_scanner #(.SCAN_DIV(2)) dut2 (
    .clock(clock), .reset(reset), .dataIn(dataIn), .loadValue(loadValue), .blank(blank),
    .ready(rdy2), .hexValue(hex2), .digitEnable(den2), .digitIndex(idx2));

  display_scanner #(.SCAN_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .dataIn(dataIn), .loadValue(loadValue), .blank(blank),
    .ready(rdy1), .hexValue(hex1), .digitEnable(den1), .digitIndex(idx1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising edges since the last reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge k.
  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (edge_n < k && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (edge_n < k) begin
      checks++;
      errors++;
      $display("FAIL goto_timeout observed=%0d expected=%0d", edge_n, k);
    end
  endtask

  initial begin
    reset = 1'b1; loadValue = 1'b0; blank = 1'b0; dataIn = 16'h0000;
    repeat (2) @(negedge clock);
    chk("rst_ready4", rdy4, 1'b1);
    chk("rst_hex4",   hex4, 4'h0);
    chk("rst_den4",   den4, 4'b1111);
    chk("rst_idx4",   idx4, 2'd0);
    chk("rst_ready2", rdy2, 1'b1);
    chk("rst_ready1", rdy1, 1'b1);
    chk("rst_hex1",   hex1, 4'h0);
    reset = 1'b0;

    goto(1);
    chk("rel_den4", den4, 4'b1110);
    chk("rel_idx4", idx4, 2'd0);
    chk("rel_den2", den2, 4'b1110);
    goto(3);  chk("div4_idx_e3",  idx4, 2'd0);
    goto(4);  chk("div4_idx_e4",  idx4, 2'd1);
    goto(8);  chk("div4_idx_e8",  idx4, 2'd2);
    goto(12); chk("div4_idx_e12", idx4, 2'd3);
    goto(16); chk("div4_idx_e16", idx4, 2'd0);

    // Load mid-frame; the next boundary is edge 24.
    goto(17); dataIn = 16'h1A3F; loadValue = 1'b1;
    goto(18); chk("load_ready_low", rdy2, 1'b0); loadValue = 1'b0; dataIn = 16'h0000;
    goto(23); chk("load_ready_pre", rdy2, 1'b0); chk("load_hex_old", hex2, 4'h0);
    goto(24); chk("load_ready_up", rdy2, 1'b1); chk("load_idx0", idx2, 2'd0);
              chk("load_hex_d0", hex2, 4'hF); chk("load_den_d0", den2, 4'b1110);
    goto(26); chk("load_hex_d1", hex2, 4'h3); chk("load_den_d1", den2, 4'b1101);
    goto(28); chk("load_hex_d2", hex2, 4'hA);
    goto(30); chk("load_hex_d3", hex2, 4'h1); chk("load_den_d3", den2, 4'b0111);

    // Back-pressure: 2222 arrives while the slot is full and must be dropped.
    goto(32); dataIn = 16'h1111; loadValue = 1'b1;
    goto(33); chk("bp_ready_low", rdy2, 1'b0); dataIn = 16'h2222;
    goto(35); loadValue = 1'b0; dataIn = 16'h0000;
    goto(39); chk("bp_ready_pre", rdy2, 1'b0);
    goto(40); chk("bp_ready_up", rdy2, 1'b1); chk("bp_hex_d0", hex2, 4'h1);
    goto(46); chk("bp_idx3", idx2, 2'd3); chk("bp_hex_d3", hex2, 4'h1);
    goto(48); chk("bp_ready_next", rdy2, 1'b1); chk("bp_hex_next", hex2, 4'h1);

    // Load accepted on the boundary edge 56; shown from boundary 64.
    goto(55); dataIn = 16'h00C0; loadValue = 1'b1;
    goto(56); chk("sim_ready_low", rdy2, 1'b0); chk("sim_hex_old", hex2, 4'h1);
              chk("sim_idx0", idx2, 2'd0); loadValue = 1'b0; dataIn = 16'h0000;
    goto(62); chk("sim_idx3", idx2, 2'd3); chk("sim_hex_old_d3", hex2, 4'h1);
    goto(63); chk("sim_ready_pre", rdy2, 1'b0);
    goto(64); chk("sim_ready_up", rdy2, 1'b1); chk("sim_hex_d0", hex2, 4'h0);
              chk("sim_den_d0", den2, 4'b1110);
    goto(66); chk("sim_hex_d1", hex2, 4'hC); chk("sim_den_d1", den2, 4'b1101);
    goto(68); chk("sim_hex_d2", hex2, 4'h0); chk("zb_c0_den_d2", den2, ZB ? 4'b1111 : 4'b1011);

    // Blank for edges 71..80 while scanning and a load continue.
    goto(70); blank = 1'b1;
    goto(71); chk("blank_den", den2, 4'b1111); chk("blank_idx3", idx2, 2'd3);
    goto(72); dataIn = 16'h0050; loadValue = 1'b1;
    goto(73); chk("blank_load_taken", rdy2, 1'b0); loadValue = 1'b0; dataIn = 16'h0000;
    goto(76); chk("blank_idx2", idx2, 2'd2); chk("blank_den_mid", den2, 4'b1111);
    goto(80); chk("blank_ready_up", rdy2, 1'b1); chk("blank_idx0", idx2, 2'd0);
              chk("blank_den_end", den2, 4'b1111); chk("blank_hex_d0", hex2, 4'h0);
              blank = 1'b0;
    goto(81); chk("unblank_den", den2, 4'b1110);
    goto(82); chk("v50_hex_d1", hex2, 4'h5); chk("v50_den_d1", den2, 4'b1101);
    goto(84); chk("zb_50_den_d2", den2, ZB ? 4'b1111 : 4'b1011);
    goto(86); chk("zb_50_den_d3", den2, ZB ? 4'b1111 : 4'b0111);

    // All-zero value: only digit 0 survives suppression.
    dataIn = 16'h0000; loadValue = 1'b1;
    goto(87); chk("v0_ready_low", rdy2, 1'b0); loadValue = 1'b0;
    goto(88); chk("v0_ready_up", rdy2, 1'b1); chk("v0_hex_d0", hex2, 4'h0);
              chk("v0_den_d0", den2, 4'b1110);
    goto(90); chk("zb_0_den_d1", den2, ZB ? 4'b1111 : 4'b1101);
              chk("div1_idx_e90", idx1, 2'd2);
    goto(91); chk("div1_idx_e91", idx1, 2'd3);
    goto(92); chk("div1_idx_e92", idx1, 2'd0); chk("div1_den_e92", den1, 4'b1110);

    // Reset mid-handshake discards the pending value.
    dataIn = 16'hABCD; loadValue = 1'b1;
    goto(93); chk("mid_ready_low", rdy2, 1'b0); loadValue = 1'b0; dataIn = 16'h0000;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", rdy2, 1'b1);
    chk("mid_rst_den",   den2, 4'b1111);
    chk("mid_rst_idx",   idx2, 2'd0);
    chk("mid_rst_hex",   hex2, 4'h0);
    @(negedge clock);
    reset = 1'b0;
    goto(1); chk("mid_rel_den", den2, 4'b1110);
    goto(8); chk("mid_frame_ready", rdy2, 1'b1); chk("mid_frame_hex", hex2, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range is 1 or more.
REQ-002 Port clock, input, 1, the only clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port dataIn, input, 16, four hex nibbles to display; digit 0 is bits [3:0] and digit 3 is bits [15:12].
REQ-005 Port loadValue, input, 1, load strobe; sampled only when ready=1.
REQ-006 Port blank, input, 1, turns all digits off while high.
REQ-007 Port ready, output, 1, high when the pending slot is empty and a load will be accepted.
REQ-008 Port hexValue, output, 4, nibble of the active digit; feeds the downstream 7-segment decoder.
REQ-009 Port digitEnable, output, 4, active-low one-hot digit select; 4'b1111 means all digits off.
REQ-010 Port digitIndex, output, 2, index of the active digit.

Function
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1 and assert a one-cycle tick on the terminal count, then wrap to 0.
REQ-012 On each tick, digitIndex SHALL advance 0->1->2->3->0; between ticks it SHALL hold.
REQ-013 When loadValue=1 and ready=1 on a clock edge, dataIn SHALL be captured into the pending register, and ready SHALL go 0 on the next cycle.
REQ-014 When loadValue=1 and ready=0, the strobe SHALL be ignored with no state change, and the pending value SHALL be kept.
REQ-015 On the tick that wraps digitIndex from 3 to 0 (frame boundary), a valid pending value SHALL be copied into the display register, and ready SHALL return to 1 on the next cycle.
REQ-016 The display register SHALL change only at a frame boundary, so no partial frame mixes old and new data.
REQ-017 If a load is accepted on the same edge as a frame boundary, the boundary copy SHALL see an empty pending slot, and the new value SHALL be displayed from the following frame boundary.
REQ-018 hexValue SHALL equal display-register nibble [digitIndex], combinationally from registered state.
REQ-019 digitEnable SHALL be registered; each cycle it SHALL load 4'b1111 if blank=1, otherwise a single 0 at bit digitIndex (next-state value).
REQ-020 blank SHALL NOT stop the prescaler, digitIndex or the load/ready handshake.
REQ-021 With SCAN_DIV=1, the tick SHALL be asserted every cycle and digitIndex SHALL advance every cycle.

Reset
REQ-022 While reset=1: prescaler=0, digitIndex=0, display register=16'h0000, pending empty, ready=1, digitEnable=4'b1111.
REQ-023 On the first edge after reset release with blank=0, digitEnable SHALL become 4'b1110.
REQ-024 Reset asserted mid-frame or mid-handshake SHALL discard any pending value with no output glitch beyond the reset values.

Configuration
REQ-025 With macro DISPLAY_ZERO_BLANK_EN defined, leading-zero suppression SHALL apply: digits above the highest nonzero nibble of the display register SHALL read 1 in digitEnable; digit 0 is always enabled (unless blank), so value 0 shows a single "0".
REQ-026 Without DISPLAY_ZERO_BLANK_EN, all four digits SHALL be scanned regardless of value; ports and timing SHALL be identical in both builds.

Structure
REQ-027 Shared package display_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=4 and DIGIT_OFF=4'b1111 for use by this block and the decoder.
REQ-028 The prescaler SHALL be a sub-module named scan_prescaler (parameter SCAN_DIV, outputs tick); the digit and handshake logic stays in display_scanner.

Verification
REQ-029 Reset check: with SCAN_DIV=4, assert then release reset -> ready=1, hexValue=0, digitEnable=4'b1111 then 4'b1110; digitIndex steps every 4 cycles as 0,1,2,3,0.
REQ-030 Load check: with SCAN_DIV=2, load 16'h1A3F mid-frame -> ready=0 until the frame boundary; hexValue sequence thereafter is F,3,A,1.
REQ-031 Back-pressure check: load 16'h1111 then 16'h2222 while ready=0 -> 16'h2222 is dropped, 16'h1111 is displayed, and ready returns to 1 one cycle after the boundary.
REQ-032 Simultaneous check: load 16'h00C0 on the 3->0 boundary edge -> the old value is kept for one more frame and 16'h00C0 is shown from the next boundary.
REQ-033 Blank check: raise blank for 10 cycles -> digitEnable=4'b1111 one cycle later, digitIndex keeps advancing, and a load is still accepted.
REQ-034 Zero-blank check, with DISPLAY_ZERO_BLANK_EN: display 16'h0050 -> digits 3 and 2 stay off; display 16'h0000 -> only digit 0 is enabled.
